// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    MATCH = 2'd2
  } state_t;

  function automatic logic len_legal(input int unsigned pat_len, input int unsigned max_len);
    return (pat_len >= 1) && (pat_len <= max_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with inc yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Moore serial pattern detector with runtime pattern/length, overlap control
// and a saturating match counter.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [MAX_LEN-1:0]           pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic                         overlap,
  input  logic                         valid,
  input  logic                         din,
  input  logic                         clr_cnt,
  output logic                         match,
  output logic                         busy,
  output logic                         cfg_err,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int LW = $clog2(MAX_LEN+1);

  state_t             state;
  logic [MAX_LEN-1:0] win;
  logic [LW-1:0]      fill;
  logic [MAX_LEN-1:0] pat_q;
  logic [LW-1:0]      len_q;
  logic               ovl_q;

  logic               len_ok;
  logic               accept;
  logic [MAX_LEN-1:0] win_next;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  assign len_ok   = len_legal(32'(pat_len), MAX_LEN);
  assign cfg_err  = (state == IDLE) && en && !len_ok;
  assign accept   = (state != IDLE) && en && valid;
  assign win_next = {win[MAX_LEN-2:0], din};
  assign fill_inc = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);

  // Only the low len_q bits of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign hit = accept && (fill_inc >= len_q) && ((win_next & mask) == (pat_q & mask));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      win   <= '0;
      fill  <= '0;
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      match <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          match <= 1'b0;
          busy  <= 1'b0;
          if (en && len_ok) begin
            pat_q <= pattern;
            len_q <= pat_len;
            ovl_q <= overlap;
            win   <= '0;
            fill  <= '0;
            state <= HUNT;
            busy  <= 1'b1;
          end
        end
        HUNT, MATCH: begin
          if (!en) begin
            // Abort discards any bit presented on this edge.
            win   <= '0;
            fill  <= '0;
            state <= IDLE;
            match <= 1'b0;
            busy  <= 1'b0;
          end else begin
            if (valid) begin
              win  <= win_next;
              fill <= (hit && !ovl_q) ? '0 : fill_inc;
            end
            state <= hit ? MATCH : HUNT;
            match <= hit;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          match <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (clr_cnt),
    .q     (match_cnt)
  );

endmodule
